bram_burst_master: RTL and testbench

- Initiator-side controller that drives a single-port synchronous block RAM.
- The RAM has 1-cycle registered read latency and write-first-cycle semantics.
- Accepts burst read/write requests from a client (CPU/DMA) over valid/ready handshakes, then sequences per-word RAM accesses with address auto-increment.
- Returns read data through a 2-entry skid buffer with backpressure; sits between the core's memory stage and the BRAM.

---
 rtl/bram_burst_master_pkg.sv | 14 +
 rtl/bram_skid_fifo.sv | 57 +++++
 rtl/bram_burst_master.sv | 154 +++++++++++++++
 tb/tb_bram_burst_master.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_burst_master_pkg.sv
// Shared types and constants for the BRAM burst master and its read-return FIFO.
package bram_burst_master_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain
  } state_e;

  // Read-return buffering; also bounds outstanding reads (buffered + in flight).
  localparam int unsigned SkidDepth = 2;

endpackage

// File: rtl/bram_skid_fifo.sv
// Two-entry FIFO for returned read words; simultaneous push and pop allowed.
module bram_skid_fifo
  import bram_burst_master_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  localparam logic [1:0] Full = 2'(SkidDepth);

  logic [WIDTH-1:0] mem_q [SkidDepth];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != Full) || do_pop);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SkidDepth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bram_burst_master.sv
// Burst read/write initiator for a single-port BRAM with 1-cycle registered reads.
module bram_burst_master
  import bram_burst_master_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_BITS = 9,
  parameter int unsigned LEN_BITS      = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [RAM_ADDR_BITS-1:0] req_addr,
  input  logic [LEN_BITS-1:0]      req_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [RAM_WIDTH-1:0]     wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [RAM_WIDTH-1:0]     rd_data,
  output logic                     done,
  output logic                     ram_enable,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] address,
  output logic [RAM_WIDTH-1:0]     input_data,
  input  logic [RAM_WIDTH-1:0]     output_data
);

  localparam logic [RAM_ADDR_BITS-1:0] AddrOne = 1;
  localparam logic [LEN_BITS-1:0]      LenOne  = 1;

  state_e                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_BITS-1:0]      len_q, len_d;
  logic [LEN_BITS-1:0]      beats_left_q, beats_left_d;
  logic [LEN_BITS-1:0]      issued_q, issued_d;
  logic [LEN_BITS-1:0]      delivered_q, delivered_d;
  logic                     inflight_q, inflight_d;
  logic                     done_q, done_d;

  logic [1:0] skid_count;
  logic       pop;
  logic [2:0] occupancy;
  logic       issue_ok;

  assign rd_valid = (skid_count != 2'd0);
  assign pop      = rd_valid && rd_ready;
  assign done     = done_q;

  // A word popped this cycle frees its slot now, keeping reads at one word per cycle.
  assign occupancy = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue_ok  = (occupancy < 3'(SkidDepth));

  bram_skid_fifo #(
    .WIDTH(RAM_WIDTH)
  ) u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (inflight_q),
    .push_data(output_data),
    .pop      (pop),
    .count    (skid_count),
    .head     (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    len_d        = len_q;
    beats_left_d = beats_left_q;
    issued_d     = issued_q;
    delivered_d  = pop ? (delivered_q + LenOne) : delivered_q;
    inflight_d   = 1'b0;
    done_d       = 1'b0;
    req_ready    = 1'b0;
    wr_ready     = 1'b0;
    ram_enable   = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    input_data   = '0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cur_addr_d   = req_addr;
          len_d        = req_len;
          beats_left_d = req_len;
          issued_d     = '0;
          delivered_d  = '0;
          state_d      = req_write ? StWrite : StRead;
        end
      end
      StWrite: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_enable   = 1'b1;
          write_enable = 1'b1;
          address      = cur_addr_q;
          input_data   = wr_data;
          cur_addr_d   = cur_addr_q + AddrOne;
          beats_left_d = beats_left_q - LenOne;
          if (beats_left_q == '0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRead: begin
        if (issue_ok) begin
          ram_enable = 1'b1;
          address    = cur_addr_q;
          inflight_d = 1'b1;
          cur_addr_d = cur_addr_q + AddrOne;
          issued_d   = issued_q + LenOne;
          if (issued_q == len_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && (delivered_q == len_q)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cur_addr_q   <= '0;
      len_q        <= '0;
      beats_left_q <= '0;
      issued_q     <= '0;
      delivered_q  <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      len_q        <= len_d;
      beats_left_q <= beats_left_d;
      issued_q     <= issued_d;
      delivered_q  <= delivered_d;
      inflight_q   <= inflight_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_bram_burst_master.sv
// Randomized bench for bram_burst_master with a RAM model and a burst-level reference model.
module tb_bram_burst_master;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [8:0]  req_addr;
  logic [3:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        done;
  logic        ram_enable, write_enable;
  logic [8:0]  address;
  logic [31:0] input_data, output_data;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Observations recorded by the compare process, read by the stimulus process.
  logic [8:0]  wr_addr_log[$];
  logic [31:0] rd_log[$];
  int          n_issues = 0;
  int          n_done = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  bram_burst_master #(
    .RAM_WIDTH    (32),
    .RAM_ADDR_BITS(9),
    .LEN_BITS     (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .done        (done),
    .ram_enable  (ram_enable),
    .write_enable(write_enable),
    .address     (address),
    .input_data  (input_data),
    .output_data (output_data)
  );

  function automatic logic [31:0] preload(int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Synchronous single-port RAM, registered read, write-first.
  logic [31:0] ram [512];
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = preload(i);
    output_data = '0;
    forever begin
      @(posedge clock);
      if (ram_enable) begin
        if (write_enable) begin
          ram[address] <= input_data;
          output_data  <= input_data;
        end else begin
          output_data <= ram[address];
        end
      end
    end
  end

  // Reference model: burst-level bookkeeping checked every cycle.
  logic [31:0] model_mem [512];
  initial begin
    int          m_phase, m_len, m_idx, m_pop, m_outst, m_acc, m_first_issue;
    bit          done_due, seen_valid;
    logic [8:0]  m_addr, ea;
    logic        pop;
    for (int i = 0; i < 512; i++) model_mem[i] = preload(i);
    m_phase = 0; done_due = 0; seen_valid = 0;
    m_len = 0; m_idx = 0; m_pop = 0; m_outst = 0; m_acc = 0; m_first_issue = 0; m_addr = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_wr_ready", 64'(wr_ready), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ram_enable", 64'(ram_enable), 64'(0));
        chk("rst_write_enable", 64'(write_enable), 64'(0));
        chk("rst_address", 64'(address), 64'(0));
        chk("rst_input_data", 64'(input_data), 64'(0));
        m_phase = 0;
        done_due = 0;
        continue;
      end
      chk("done_pulse", 64'(done), 64'(done_due));
      if (done) n_done++;
      done_due = 0;
      case (m_phase)
        0: begin
          chk("idle_req_ready", 64'(req_ready), 64'(1));
          chk("idle_wr_ready", 64'(wr_ready), 64'(0));
          chk("idle_ram_enable", 64'(ram_enable), 64'(0));
          chk("idle_rd_valid", 64'(rd_valid), 64'(0));
          if (req_valid) begin
            m_phase = req_write ? 1 : 2;
            m_addr = req_addr; m_len = int'(req_len);
            m_idx = 0; m_pop = 0; m_outst = 0; m_acc = cyc; seen_valid = 0;
          end
        end
        1: begin
          chk("w_req_ready", 64'(req_ready), 64'(0));
          chk("w_wr_ready", 64'(wr_ready), 64'(1));
          chk("w_rd_valid", 64'(rd_valid), 64'(0));
          if (wr_valid) begin
            ea = m_addr + 9'(m_idx);
            chk("w_ram_enable", 64'(ram_enable), 64'(1));
            chk("w_write_enable", 64'(write_enable), 64'(1));
            chk("w_address", 64'(address), 64'(ea));
            chk("w_input_data", 64'(input_data), 64'(wr_data));
            model_mem[ea] = wr_data;
            wr_addr_log.push_back(address);
            m_idx++;
            if (m_idx == m_len + 1) begin
              done_due = 1;
              m_phase = 0;
            end
          end else begin
            chk("w_stall_ram_enable", 64'(ram_enable), 64'(0));
          end
        end
        default: begin
          pop = rd_valid && rd_ready;
          chk("r_req_ready", 64'(req_ready), 64'(0));
          chk("r_wr_ready", 64'(wr_ready), 64'(0));
          chk("r_outstanding_le2", 64'(m_outst <= 2), 64'(1));
          if (rd_valid) chk("r_valid_backed", 64'(m_outst > 0), 64'(1));
          if (ram_enable) begin
            chk("r_write_enable", 64'(write_enable), 64'(0));
            chk("r_address", 64'(address), 64'(m_addr + 9'(m_idx)));
            chk("r_issue_count", 64'(m_idx <= m_len), 64'(1));
            chk("r_issue_room", 64'((m_outst - int'(pop)) < 2), 64'(1));
            if (m_idx == 0) begin
              chk("issue_latency", 64'(cyc - m_acc), 64'(1));
              m_first_issue = cyc;
            end
            m_idx++;
            n_issues++;
          end
          if (rd_valid && !seen_valid) begin
            chk("rd_valid_latency", 64'(cyc - m_first_issue), 64'(2));
            seen_valid = 1;
          end
          if (pop) begin
            chk("r_rd_data", 64'(rd_data), 64'(model_mem[m_addr + 9'(m_pop)]));
            rd_log.push_back(rd_data);
            m_pop++;
            if (m_pop == m_len + 1) begin
              done_due = 1;
              m_phase = 0;
            end
          end
          m_outst = m_outst + int'(ram_enable) - int'(pop);
        end
      endcase
    end
  end

  // Every stimulus task starts and ends 1 time unit after a rising edge.
  task automatic wait_done(output int dcyc);
    bit got = 0;
    dcyc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (done) begin
        got = 1;
        dcyc = cyc;
      end
      @(posedge clock); #1;
    end
    chk("done_seen", 64'(got), 64'(1));
  endtask

  task automatic send_req(input bit w, input logic [8:0] a, input logic [3:0] l, output int acc);
    req_valid = 1; req_write = w; req_addr = a; req_len = l;
    @(negedge clock);
    acc = cyc;
    @(posedge clock); #1;
    req_valid = 0;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [3:0] l, input logic [31:0] base,
                          input bit rnd, input int prob, output int acc, output int dcyc);
    int k = 0;
    int t = 0;
    bit hs;
    send_req(1'b1, a, l, acc);
    while (k <= int'(l) && t < 300) begin
      wr_valid = ($urandom_range(99) < prob);
      wr_data  = rnd ? $urandom : base + 32'(k);
      @(negedge clock);
      hs = wr_valid && wr_ready;
      @(posedge clock); #1;
      if (hs) k++;
      t++;
    end
    wr_valid = 0;
    chk("wr_beats_taken", 64'(k), 64'(int'(l) + 1));
    wait_done(dcyc);
  endtask

  // mode 0: rd_ready held high; 1: fixed 1,0,0,1,0,1 pattern; 2: random.
  task automatic do_read(input logic [8:0] a, input logic [3:0] l, input int mode,
                         output int acc, output int dcyc);
    bit pat [6];
    bit got = 0;
    pat = '{1, 0, 0, 1, 0, 1};
    dcyc = 0;
    send_req(1'b0, a, l, acc);
    for (int i = 0; i < 300 && !got; i++) begin
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[i % 6] : 1'($urandom_range(1));
      @(negedge clock);
      if (done) begin
        got = 1;
        dcyc = cyc;
      end
      @(posedge clock); #1;
    end
    rd_ready = 0;
    chk("rd_done_seen", 64'(got), 64'(1));
  endtask

  initial begin
    int acc, dcyc, b, ni, nd;
    logic [8:0] wrap_exp [3];
    req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0;
    reset_n = 0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1;
    @(posedge clock); #1;

    // Directed write then read-back of 0xA0..0xA3 at 0x010.
    b = wr_addr_log.size();
    do_write(9'h010, 4'd3, 32'hA0, 1'b0, 100, acc, dcyc);
    chk("wr_burst_cycles", 64'(dcyc - acc), 64'(5));
    for (int i = 0; i < 4; i++) chk("wr_addr_seq", 64'(wr_addr_log[b + i]), 64'(9'h010 + 9'(i)));
    @(posedge clock); #1;

    b = rd_log.size();
    do_read(9'h010, 4'd3, 0, acc, dcyc);
    chk("rd_burst_cycles", 64'(dcyc - acc), 64'(7));
    for (int i = 0; i < 4; i++) chk("rd_data_seq", 64'(rd_log[b + i]), 64'(32'hA0 + 32'(i)));

    b = rd_log.size();
    do_read(9'h010, 4'd3, 1, acc, dcyc);
    chk("rd_toggle_count", 64'(rd_log.size() - b), 64'(4));
    for (int i = 0; i < 4; i++) chk("rd_toggle_seq", 64'(rd_log[b + i]), 64'(32'hA0 + 32'(i)));

    // Address wrap.
    wrap_exp = '{9'h1FF, 9'h000, 9'h001};
    b = wr_addr_log.size();
    do_write(9'h1FF, 4'd2, 32'hC0, 1'b0, 100, acc, dcyc);
    for (int i = 0; i < 3; i++) chk("wrap_addr", 64'(wr_addr_log[b + i]), 64'(wrap_exp[i]));

    // Single-word read.
    b = rd_log.size(); ni = n_issues; nd = n_done;
    do_read(9'h005, 4'd0, 0, acc, dcyc);
    chk("len0_issues", 64'(n_issues - ni), 64'(1));
    chk("len0_beats", 64'(rd_log.size() - b), 64'(1));
    chk("len0_done", 64'(n_done - nd), 64'(1));
    chk("len0_data", 64'(rd_log[b]), 64'(32'h5A00_0000 ^ 32'h0005_0A0F));

    // Randomized bursts.
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(1) == 1) do_write(9'($urandom), 4'($urandom), '0, 1'b1, 70, acc, dcyc);
      else do_read(9'($urandom), 4'($urandom), 2, acc, dcyc);
    end

    // Reset during the third beat of a 4-word read.
    b = rd_log.size();
    send_req(1'b0, 9'h010, 4'd3, acc);
    rd_ready = 1;
    for (int t = 0; t < 50 && rd_log.size() < b + 2; t++) begin
      @(posedge clock); #1;
    end
    chk("pre_reset_beats", 64'(rd_log.size() - b), 64'(2));
    chk("pre_reset_rd_valid", 64'(rd_valid), 64'(1));
    reset_n = 0;
    #1;
    chk("async_req_ready", 64'(req_ready), 64'(1));
    chk("async_rd_valid", 64'(rd_valid), 64'(0));
    chk("async_rd_data", 64'(rd_data), 64'(0));
    chk("async_ram_enable", 64'(ram_enable), 64'(0));
    chk("async_address", 64'(address), 64'(0));
    chk("async_done", 64'(done), 64'(0));
    rd_ready = 0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1;
    @(posedge clock); #1;
    chk("post_reset_beats", 64'(rd_log.size() - b), 64'(2));

    do_write(9'h020, 4'd3, 32'hD0, 1'b0, 100, acc, dcyc);
    chk("post_reset_wr_cycles", 64'(dcyc - acc), 64'(5));
    b = rd_log.size();
    do_read(9'h020, 4'd3, 2, acc, dcyc);
    for (int i = 0; i < 4; i++) chk("post_reset_rd", 64'(rd_log[b + i]), 64'(32'hD0 + 32'(i)));

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
